maria_bus_arbiter: RTL and testbench

- Owns the shared 16-bit system address bus between the 6502 CPU and the Maria DMA engine.
- Accepts the DMA engine's HALT request and waits for the CPU to finish its current bus cycle. It then stalls the CPU (RDY low) and hands bus ownership to DMA.
- On DMA release it returns the bus to the CPU after a programmable turnaround.
- Sits between the CPU core, dma_ctrl and the memory/cart address decode.

---
 rtl/maria_bus_pkg.sv | 22 ++
 rtl/arb_delay_counter.sv | 45 ++++
 rtl/maria_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_maria_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maria_bus_pkg.sv
// +----------------------------------------------------------------------------+
// | maria_bus_pkg: shared state encodings and widths for the Maria bus arbiter |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package maria_bus_pkg;

  localparam int CNT_W = 3;

  localparam logic [2:0] CPU_OWN  = 3'd0;
  localparam logic [2:0] WAIT_CPU = 3'd1;
  localparam logic [2:0] HANDOVER = 3'd2;
  localparam logic [2:0] DMA_OWN  = 3'd3;
  localparam logic [2:0] RELEASE  = 3'd4;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_delay_counter.sv
// +----------------------------------------------------------------------------+
// | arb_delay_counter: loadable down-counter with zero flag for turnarounds    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module arb_delay_counter
  import maria_bus_pkg::*;
(
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/maria_bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | maria_bus_arbiter: hands the 16-bit system bus between 6502 and Maria DMA. |
// | Optional ARB_STATS_EN adds vblank input and per-frame dma_ticks counter.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module maria_bus_arbiter
  import maria_bus_pkg::*;
#(
  parameter int GRANT_DELAY   = 1,
  parameter int RELEASE_DELAY = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        mclk0,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        cpu_cycle_end,
  input  logic        dma_halt,
  input  logic [15:0] dma_addr,
  input  logic        dma_drive,
`ifdef ARB_STATS_EN
  input  logic        vblank,
  output logic [15:0] dma_ticks,
`endif
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic        bus_owner,
  output logic        cpu_rdy,
  output logic        dma_grant
);

  if (GRANT_DELAY < 1 || GRANT_DELAY > 7) begin : g_bad_grant_delay
    $error("maria_bus_arbiter: GRANT_DELAY must be within 1..7");
  end
  if (RELEASE_DELAY < 1 || RELEASE_DELAY > 7) begin : g_bad_release_delay
    $error("maria_bus_arbiter: RELEASE_DELAY must be within 1..7");
  end

  localparam logic [CNT_W-1:0] c_grant_load   = CNT_W'(GRANT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_release_load = CNT_W'(RELEASE_DELAY - 1);

  logic [2:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             rdy_q, rdy_d;
  logic [15:0]      dma_addr_hold_q, dma_addr_hold_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  arb_delay_counter u_delay (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .en       (mclk0),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  // A halt drop always wins over a pending cycle end or an expiring count.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rdy_d        = rdy_q;
    cnt_load     = 1'b0;
    cnt_load_val = c_grant_load;
    cnt_dec      = 1'b0;
    case (state_q)
      CPU_OWN: begin
        if (dma_halt) begin
          state_d = WAIT_CPU;
          rdy_d   = 1'b0;
        end
      end
      WAIT_CPU: begin
        if (!dma_halt) begin
          state_d = CPU_OWN;
          rdy_d   = 1'b1;
        end else if (cpu_cycle_end) begin
          state_d  = HANDOVER;
          cnt_load = 1'b1;
        end
      end
      HANDOVER: begin
        if (!dma_halt) begin
          state_d      = RELEASE;
          cnt_load     = 1'b1;
          cnt_load_val = c_release_load;
        end else if (cnt_zero) begin
          state_d = DMA_OWN;
          owner_d = OWNER_DMA;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DMA_OWN: begin
        if (!dma_halt) begin
          state_d      = RELEASE;
          owner_d      = OWNER_CPU;
          cnt_load     = 1'b1;
          cnt_load_val = c_release_load;
        end
      end
      RELEASE: begin
        // A re-request keeps the CPU stalled but it must still finish a cycle.
        if (dma_halt) begin
          state_d = WAIT_CPU;
        end else if (cnt_zero) begin
          state_d = CPU_OWN;
          rdy_d   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = CPU_OWN;
        owner_d = OWNER_CPU;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    dma_addr_hold_d = dma_drive ? dma_addr : dma_addr_hold_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q         <= CPU_OWN;
      owner_q         <= OWNER_CPU;
      rdy_q           <= 1'b1;
      dma_addr_hold_q <= 16'h0000;
    end else if (mclk0) begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      rdy_q           <= rdy_d;
      dma_addr_hold_q <= dma_addr_hold_d;
    end
  end

  always_comb begin
    bus_addr = cpu_addr;
    if (owner_q == OWNER_DMA) begin
      bus_addr = dma_drive ? dma_addr : dma_addr_hold_q;
    end
  end

  assign bus_rw    = (owner_q == OWNER_DMA) ? 1'b1 : cpu_rw;
  assign bus_owner = owner_q;
  assign dma_grant = owner_q;
  assign cpu_rdy   = rdy_q;

`ifdef ARB_STATS_EN
  logic        vblank_q, vblank_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] dma_ticks_q, dma_ticks_d;
  logic [15:0] acc_inc;

  // A DMA tick landing on the vblank edge belongs to the new frame.
  always_comb begin
    vblank_d    = vblank;
    dma_ticks_d = dma_ticks_q;
    acc_inc     = (owner_q && (acc_q != 16'hFFFF)) ? acc_q + 16'd1 : acc_q;
    acc_d       = acc_inc;
    if (vblank && !vblank_q) begin
      dma_ticks_d = acc_q;
      acc_d       = owner_q ? 16'd1 : 16'd0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vblank_q    <= 1'b0;
      acc_q       <= 16'd0;
      dma_ticks_q <= 16'd0;
    end else if (mclk0) begin
      vblank_q    <= vblank_d;
      acc_q       <= acc_d;
      dma_ticks_q <= dma_ticks_d;
    end
  end

  assign dma_ticks = dma_ticks_q;
`endif

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

endmodule

`default_nettype wire

// File: tb/tb_maria_bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_maria_bus_arbiter: vector table + scoreboard bench for the bus arbiter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_maria_bus_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        mclk0;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic        cpu_cycle_end;
  logic        dma_halt;
  logic [15:0] dma_addr;
  logic        dma_drive;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic        bus_owner;
  logic        cpu_rdy;
  logic        dma_grant;
`ifdef ARB_STATS_EN
  logic        vblank;
  logic [15:0] dma_ticks;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  maria_bus_arbiter #(
    .GRANT_DELAY   (1),
    .RELEASE_DELAY (3)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .mclk0         (mclk0),
    .cpu_addr      (cpu_addr),
    .cpu_rw        (cpu_rw),
    .cpu_cycle_end (cpu_cycle_end),
    .dma_halt      (dma_halt),
    .dma_addr      (dma_addr),
    .dma_drive     (dma_drive),
`ifdef ARB_STATS_EN
    .vblank        (vblank),
    .dma_ticks     (dma_ticks),
`endif
    .bus_addr      (bus_addr),
    .bus_rw        (bus_rw),
    .bus_owner     (bus_owner),
    .cpu_rdy       (cpu_rdy),
    .dma_grant     (dma_grant)
  );

  typedef struct {
    logic        halt;
    logic        cend;
    logic        drive;
    logic        rw;
    logic [15:0] caddr;
    logic [15:0] daddr;
    logic        e_owner;
    logic        e_rdy;
    logic        e_grant;
    logic        e_rw;
    logic [15:0] e_addr;
  } vec_t;

  typedef struct {
    int          idx;
    logic        owner;
    logic        rdy;
    logic        grant;
    logic        rw;
    logic [15:0] addr;
  } exp_t;

  vec_t vecs[26];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One idle clk_sys cycle with mclk0 low, then one enabled tick; sample 1ns later.
  task automatic do_tick();
    @(negedge clk_sys);
    mclk0 = 1'b0;
    @(negedge clk_sys);
    mclk0 = 1'b1;
    @(posedge clk_sys);
    #1;
    mclk0 = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_cycle_end = 1'b0;
    dma_drive     = 1'b0;
    cpu_addr      = 16'hF000;
    dma_addr      = 16'h1800;
    cpu_rw        = 1'b1;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    mclk0 = 1'b0;
    dma_halt = 1'b0;
    idle_inputs();
`ifdef ARB_STATS_EN
    vblank = 1'b0;
`endif

    //          halt cend drv rw  caddr     daddr    | own rdy gnt rw  addr
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b1,1'b0,1'b1,16'hF000};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,16'hF004,16'h1800, 1'b0,1'b0,1'b0,1'b0,16'hF004};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,16'hF000,16'h1800, 1'b1,1'b0,1'b1,1'b1,16'h1800};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,16'hF000,16'h1234, 1'b1,1'b0,1'b1,1'b1,16'h1800};
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b0,16'hF000,16'h1234, 1'b1,1'b0,1'b1,1'b1,16'h1234};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b0,16'hF000};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b1,1'b0,1'b1,16'hF000};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b1,1'b0,1'b1,16'hF000};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[14] = '{1'b0,1'b1,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b1,1'b0,1'b1,16'hF000};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[16] = '{1'b1,1'b1,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[18] = '{1'b1,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[19] = '{1'b1,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[20] = '{1'b1,1'b1,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[21] = '{1'b1,1'b0,1'b1,1'b1,16'hF000,16'h2000, 1'b1,1'b0,1'b1,1'b1,16'h2000};
    vecs[22] = '{1'b0,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[23] = '{1'b0,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[24] = '{1'b0,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b0,1'b0,1'b1,16'hF000};
    vecs[25] = '{1'b0,1'b0,1'b0,1'b1,16'hF000,16'h1800, 1'b0,1'b1,1'b0,1'b1,16'hF000};

    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_owner", {31'd0, bus_owner}, 32'd0);
    check("reset_rdy",   {31'd0, cpu_rdy},   32'd1);
    check("reset_grant", {31'd0, dma_grant}, 32'd0);
    check("reset_addr",  {16'd0, bus_addr},  {16'd0, 16'hF000});
    check("reset_rw",    {31'd0, bus_rw},    32'd1);
`ifdef ARB_STATS_EN
    check("reset_dma_ticks", {16'd0, dma_ticks}, 32'd0);
`endif
    @(negedge clk_sys);
    reset = 1'b0;

    // Table run: expectation queued with the stimulus, retired after the tick.
    for (int i = 0; i < 26; i++) begin
      dma_halt      = vecs[i].halt;
      cpu_cycle_end = vecs[i].cend;
      dma_drive     = vecs[i].drive;
      cpu_rw        = vecs[i].rw;
      cpu_addr      = vecs[i].caddr;
      dma_addr      = vecs[i].daddr;
      sb.push_back('{i, vecs[i].e_owner, vecs[i].e_rdy, vecs[i].e_grant,
                     vecs[i].e_rw, vecs[i].e_addr});
      do_tick();
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d_owner", e.idx), {31'd0, bus_owner}, {31'd0, e.owner});
        check($sformatf("vec%0d_rdy", e.idx),   {31'd0, cpu_rdy},   {31'd0, e.rdy});
        check($sformatf("vec%0d_grant", e.idx), {31'd0, dma_grant}, {31'd0, e.grant});
        check($sformatf("vec%0d_rw", e.idx),    {31'd0, bus_rw},    {31'd0, e.rw});
        check($sformatf("vec%0d_addr", e.idx),  {16'd0, bus_addr},  {16'd0, e.addr});
      end
    end
    check("scoreboard_drained", sb.size(), 32'd0);
    idle_inputs();

    // A cycle-end pulse on a non-tick clock must be ignored.
    dma_halt = 1'b1;
    do_tick();
    check("gate_wait_rdy", {31'd0, cpu_rdy}, 32'd0);
    @(negedge clk_sys);
    cpu_cycle_end = 1'b1;
    @(negedge clk_sys);
    cpu_cycle_end = 1'b0;
    do_tick();
    do_tick();
    check("gate_no_grant", {31'd0, dma_grant}, 32'd0);
    cpu_cycle_end = 1'b1;
    do_tick();
    cpu_cycle_end = 1'b0;
    do_tick();
    check("gate_grant", {31'd0, dma_grant}, 32'd1);

    // Reset while DMA owns the bus, applied on a non-tick clock.
    @(negedge clk_sys);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    check("rst_mid_grant", {31'd0, dma_grant}, 32'd0);
    check("rst_mid_rdy",   {31'd0, cpu_rdy},   32'd1);
    check("rst_mid_owner", {31'd0, bus_owner}, 32'd0);
    check("rst_mid_addr",  {16'd0, bus_addr},  {16'd0, 16'hF000});
    dma_halt = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    do_tick();
    check("post_rst_rdy", {31'd0, cpu_rdy}, 32'd1);

`ifdef ARB_STATS_EN
    vblank = 1'b1;
    do_tick();
    vblank = 1'b0;
    do_tick();
    dma_halt = 1'b1;
    do_tick();
    cpu_cycle_end = 1'b1;
    do_tick();
    cpu_cycle_end = 1'b0;
    do_tick();
    check("stats_owned", {31'd0, bus_owner}, 32'd1);
    repeat (99) do_tick();
    dma_halt = 1'b0;
    do_tick();
    repeat (3) do_tick();
    check("stats_rdy_back", {31'd0, cpu_rdy}, 32'd1);
    vblank = 1'b1;
    do_tick();
    check("stats_frame_100", {16'd0, dma_ticks}, 32'd100);
    vblank = 1'b0;
    do_tick();
    vblank = 1'b1;
    do_tick();
    check("stats_frame_0", {16'd0, dma_ticks}, 32'd0);
    vblank = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
